// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared defaults and multi-cycle FSM encodings for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int STAGES_DEF = 5;
    localparam int EX_IDX_DEF = 2;
    localparam int MC_LAT_DEF = 4;
    localparam int PC_W_DEF   = 32;
    localparam int MC_CNT_W   = 8;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/pipe_mc_fsm.sv
// rtl/pipe_mc_fsm.sv - multi-cycle unit sequencer: IDLE -> BUSY (MC_LAT cycles) -> DONE -> IDLE
import pipe_ctrl_pkg::*;

module pipe_mc_fsm #(
    parameter int MC_LAT = MC_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic ex_valid_i,
    input  logic flush_i,
    output logic busy_o,
    output logic done_o
);

    mc_state_t             state;
    logic [MC_CNT_W-1:0]   cnt;

    // Flush abandons the op silently, same as reset.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state  <= MC_IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (start_i && ex_valid_i) begin
                        state  <= MC_BUSY;
                        cnt    <= MC_CNT_W'(MC_LAT - 1);
                        busy_o <= 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (cnt == '0) begin
                        state  <= MC_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MC_DONE: begin
                    state  <= MC_IDLE;
                    done_o <= 1'b0;
                end
                default: begin
                    state  <= MC_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/valid/flush controller; PIPE_CTRL_PERF_EN adds stall/bubble counters
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int STAGES = STAGES_DEF,
    parameter int EX_IDX = EX_IDX_DEF,
    parameter int MC_LAT = MC_LAT_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic              in_valid_i,
    input  logic              mc_start_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   flush_pc_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] valid_o,
    output logic [PC_W-1:0]   new_pc_o,
    output logic              new_pc_we_o,
    output logic              mc_busy_o,
    output logic              mc_done_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o
`endif
);

    logic [STAGES-1:0] req;
    logic              acc;

    assign req = stallreq_i | ({{(STAGES-1){1'b0}}, mc_busy_o} << EX_IDX);

    // A stall at stage j must also hold every older stage upstream of it.
    always_comb begin
        stall_o = '0;
        acc     = 1'b0;
        if (!rst) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                acc        = acc | req[k];
                stall_o[k] = acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_o <= '0;
        end else begin
            if (!stall_o[0]) begin
                valid_o[0] <= in_valid_i;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (!stall_o[k]) begin
                    valid_o[k] <= stall_o[k-1] ? 1'b0 : valid_o[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_o    <= '0;
            new_pc_we_o <= 1'b0;
        end else begin
            new_pc_we_o <= flush_i;
            if (flush_i) begin
                new_pc_o <= flush_pc_i;
            end
        end
    end

    pipe_mc_fsm #(
        .MC_LAT(MC_LAT)
    ) u_mc_fsm (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mc_start_i),
        .ex_valid_i(valid_o[EX_IDX]),
        .flush_i   (flush_i),
        .busy_o    (mc_busy_o),
        .done_o    (mc_done_o)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic bubble_any;

    always_comb begin
        bubble_any = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (stall_o[k-1] && !stall_o[k]) begin
                bubble_any = 1'b1;
            end
        end
    end

    // Flush overrides bubble insertion, so those cycles do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_o[0] && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (bubble_any && !flush_i && (bubble_cnt_o != '1)) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, meaning the number of pipeline stages (IF=0 … WB=STAGES-1), legal range 3..8.
REQ-002 SHALL have parameter EX_IDX, default 2, meaning the stage index that owns the multi-cycle unit; legal range 1..STAGES-2.
REQ-003 SHALL have parameter MC_LAT, default 4, meaning the number of busy cycles of a multi-cycle op; legal range 2..255.
REQ-004 SHALL have parameter PC_W, default 32, meaning the redirect PC width.
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port stallreq_i  in  STAGES  per-stage stall request, bit k from stage k.
REQ-008 SHALL have port in_valid_i  in  1  fetch-stage instruction valid.
REQ-009 SHALL have port mc_start_i  in  1  single-cycle pulse from stage EX_IDX that starts a multi-cycle op.
REQ-010 SHALL have port flush_i  in  1  redirect request.
REQ-011 SHALL have port flush_pc_i  in  PC_W  redirect target.
REQ-012 SHALL have port stall_o  out  STAGES  per-stage hold enable.
REQ-013 SHALL have port valid_o  out  STAGES  registered per-stage valid bits.
REQ-014 SHALL have port new_pc_o  out  PC_W  redirect PC.
REQ-015 SHALL have port new_pc_we_o  out  1  redirect strobe.
REQ-016 SHALL have ports mc_busy_o  out  1 and mc_done_o  out  1, giving multi-cycle status.

Function
REQ-017 SHALL compute the effective request as req = stallreq_i OR (mc_busy_o at bit EX_IDX).
REQ-018 SHALL drive stall_o[k]=1 combinationally for every k<=j, where j is the highest set bit of req; stall_o SHALL be all zero when req is zero.
REQ-019 SHALL update valid per edge: if stall_o[k], hold; else if k==0, valid[0]<=in_valid_i; else if stall_o[k-1], valid[k]<=0 (bubble); else valid[k]<=valid[k-1].
REQ-020 SHALL, on flush_i=1, clear all valid bits on the next edge, overriding REQ-019 and any stall.
REQ-021 SHALL, on the edge where flush_i=1, register new_pc_o<=flush_pc_i and new_pc_we_o<=1; new_pc_we_o SHALL be a one-cycle pulse (1-cycle latency).
REQ-022 SHALL implement multi-cycle FSM states IDLE, BUSY, DONE; mc_busy_o=1 only in BUSY and mc_done_o=1 only in DONE.
REQ-023 SHALL transition IDLE->BUSY when mc_start_i && valid_o[EX_IDX], loading the counter with MC_LAT-1.
REQ-024 SHALL, in BUSY, decrement the counter each cycle and move to DONE when the counter is 0; BUSY SHALL therefore last exactly MC_LAT cycles.
REQ-025 SHALL move from DONE to IDLE unconditionally after 1 cycle.
REQ-026 SHALL ignore mc_start_i in BUSY and DONE.
REQ-027 SHALL, on flush_i in any state, force the FSM to IDLE next cycle, with no mc_done_o pulse.
REQ-028 SHALL, when flush_i and mc_start_i are simultaneous, give flush priority: no op starts.

Reset
REQ-029 SHALL, with rst=1 at an edge, set valid_o=0, new_pc_o=0, new_pc_we_o=0, FSM=IDLE and counter=0; stall_o SHALL read 0 while rst=1.
REQ-030 SHALL abandon a BUSY op on reset mid-operation without a done pulse; rst SHALL dominate flush_i.

Configuration
REQ-031 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs stall_cnt_o (32) and bubble_cnt_o (32), cleared by rst.
REQ-032 SHALL, under PIPE_CTRL_PERF_EN, increment stall_cnt_o on each cycle with stall_o[0]=1 and bubble_cnt_o on each cycle where a bubble is inserted anywhere, both saturating at all-ones.
REQ-033 SHALL, without PIPE_CTRL_PERF_EN, have neither the counter ports nor the counter logic.

Structure
REQ-034 SHALL place FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default parameter constants in the shared defines package.
REQ-035 SHALL implement the multi-cycle FSM and counter as sub-module pipe_mc_fsm, with stall priority and valid tracking in pipe_ctrl.

Verification
REQ-036 SHALL verify: stallreq_i=5'b00100 for 1 cycle with all valid -> stall_o=5'b00111, valid_o[3] becomes 0 next edge, others held.
REQ-037 SHALL verify: mc_start_i with valid_o[2]=1, MC_LAT=4 -> mc_busy_o high for 4 cycles, stall_o[2:0]=3'b111 throughout, mc_done_o high on cycle 5.
REQ-038 SHALL verify: flush_i=1 with flush_pc_i=32'h0000_0100 during BUSY -> valid_o=0, new_pc_o=32'h100, new_pc_we_o pulse of 1 cycle, FSM IDLE, no mc_done_o.
REQ-039 SHALL verify: simultaneous stallreq_i=5'b00010 and 5'b01000 -> stall_o=5'b01111, bubble enters stage 4 only.
REQ-040 SHALL verify: rst asserted during BUSY -> next cycle all outputs 0, FSM IDLE; with PIPE_CTRL_PERF_EN, both counters read 0.
REQ-041 SHALL verify: in_valid_i toggling 1,0,1 with no stalls -> valid_o pattern shifts by exactly one stage per cycle.
